// File: rtl/change_return_ctrl.sv
// ============================================================================
// change_return_ctrl : greedy coin-return sequencer between balance and hopper
// Optional CHANGE_RETURN_ACK_TIMEOUT_EN adds a hopper ack watchdog and o_fault.
// Revision: 1.0
// ============================================================================
`default_nettype none

module change_return_ctrl #(
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100,
  parameter int COIN0_VAL  = 100,
  parameter int COIN1_VAL  = 500,
  parameter int COIN2_VAL  = 1000,
  parameter int ACK_LIMIT  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TOTAL_BITS-1:0] i_total,
  input  logic                  i_trigger_return,
  input  logic                  i_activity,
  input  logic                  i_coin_ack,
  output logic                  o_coin_req,
  output logic [2:0]            o_coin_sel,
  output logic                  o_sub_valid,
  output logic [TOTAL_BITS-1:0] o_sub_val,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_residue,
  output logic [31:0]           o_wait_time
`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
  , output logic                o_fault
`endif
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_SELECT   = 2'd1;
  localparam logic [1:0] c_DISPENSE = 2'd2;
  localparam logic [1:0] c_DONE     = 2'd3;

  localparam logic [TOTAL_BITS-1:0] c_COIN0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] c_COIN1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] c_COIN2 = TOTAL_BITS'(COIN2_VAL);
  localparam logic [31:0]           c_WAIT  = 32'(WAIT_TIME);

  if (COIN0_VAL >= COIN1_VAL || COIN1_VAL >= COIN2_VAL || ACK_LIMIT < 1) begin : g_param_check
    $error("change_return_ctrl: illegal coin values or ACK_LIMIT");
  end

  logic [1:0]            r_state;
  logic [TOTAL_BITS-1:0] r_remaining;
  logic [31:0]           r_wait_time;
  logic [2:0]            r_coin_sel;
  logic                  r_sub_valid;
  logic [TOTAL_BITS-1:0] r_sub_val;
  logic [TOTAL_BITS-1:0] r_residue;
  logic [2:0]            w_fit_sel;
  logic [TOTAL_BITS-1:0] w_coin_val;
  logic                  w_ack_timeout;

  // Largest coin not exceeding what is still owed; zero when nothing fits.
  always_comb begin
    w_fit_sel = 3'b000;
    if (r_remaining >= c_COIN2)      w_fit_sel = 3'b100;
    else if (r_remaining >= c_COIN1) w_fit_sel = 3'b010;
    else if (r_remaining >= c_COIN0) w_fit_sel = 3'b001;
  end

  always_comb begin
    w_coin_val = '0;
    case (r_coin_sel)
      3'b001:  w_coin_val = c_COIN0;
      3'b010:  w_coin_val = c_COIN1;
      3'b100:  w_coin_val = c_COIN2;
      default: w_coin_val = '0;
    endcase
  end

`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
  localparam int c_ACK_W = $clog2(ACK_LIMIT + 1);
  logic [c_ACK_W-1:0] r_ack_cnt;
  logic               r_fault;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ack_cnt <= '0;
    else if (r_state == c_DISPENSE && !i_coin_ack)
      r_ack_cnt <= r_ack_cnt + 1'b1;
    else
      r_ack_cnt <= '0;
  end

  assign w_ack_timeout = (r_ack_cnt == c_ACK_W'(ACK_LIMIT - 1));
  assign o_fault       = r_fault;
`else
  assign w_ack_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= c_IDLE;
      r_remaining <= '0;
      r_wait_time <= c_WAIT;
      r_coin_sel  <= 3'b000;
      r_sub_valid <= 1'b0;
      r_sub_val   <= '0;
      r_residue   <= '0;
`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      r_sub_valid <= 1'b0;
      r_sub_val   <= '0;
      case (r_state)
        c_IDLE: begin
          if (i_trigger_return || (r_wait_time == 32'd0 && i_total != '0)) begin
            r_remaining <= i_total;
            r_state     <= c_SELECT;
          end else if (i_activity) begin
            r_wait_time <= c_WAIT;
          end else if (r_wait_time != 32'd0) begin
            r_wait_time <= r_wait_time - 32'd1;
          end
        end
        c_SELECT: begin
          if (w_fit_sel != 3'b000) begin
            r_coin_sel <= w_fit_sel;
            r_state    <= c_DISPENSE;
          end else begin
            r_coin_sel <= 3'b000;
            r_residue  <= r_remaining;
            r_state    <= c_DONE;
          end
        end
        c_DISPENSE: begin
          if (i_coin_ack) begin
            r_remaining <= r_remaining - w_coin_val;
            r_sub_valid <= 1'b1;
            r_sub_val   <= w_coin_val;
            r_state     <= c_SELECT;
          end else if (w_ack_timeout) begin
            r_coin_sel <= 3'b000;
            r_residue  <= r_remaining;
`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
            r_fault    <= 1'b1;
`endif
            r_state    <= c_DONE;
          end
        end
        default: begin
          r_wait_time <= c_WAIT;
          r_state     <= c_IDLE;
        end
      endcase
    end
  end

  assign o_coin_req  = (r_state == c_DISPENSE);
  assign o_coin_sel  = r_coin_sel;
  assign o_sub_valid = r_sub_valid;
  assign o_sub_val   = r_sub_val;
  assign o_busy      = (r_state != c_IDLE);
  assign o_done      = (r_state == c_DONE);
  assign o_residue   = r_residue;
  assign o_wait_time = r_wait_time;

endmodule

`default_nettype wire

// File: tb/tb_change_return_ctrl.sv
// ============================================================================
// tb_change_return_ctrl : randomized check of change_return_ctrl against a
// greedy-arithmetic reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_change_return_ctrl;

  localparam int TB_BITS = 31;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [TB_BITS-1:0] i_total = '0;
  logic               i_trigger_return = 1'b0;
  logic               i_activity = 1'b0;
  logic               i_coin_ack = 1'b0;
  logic               o_coin_req;
  logic [2:0]         o_coin_sel;
  logic               o_sub_valid;
  logic [TB_BITS-1:0] o_sub_val;
  logic               o_busy;
  logic               o_done;
  logic [TB_BITS-1:0] o_residue;
  logic [31:0]        o_wait_time;
`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
  logic               o_fault;
`endif

  change_return_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_total          (i_total),
    .i_trigger_return (i_trigger_return),
    .i_activity       (i_activity),
    .i_coin_ack       (i_coin_ack),
    .o_coin_req       (o_coin_req),
    .o_coin_sel       (o_coin_sel),
    .o_sub_valid      (o_sub_valid),
    .o_sub_val        (o_sub_val),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_residue        (o_residue),
    .o_wait_time      (o_wait_time)
`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
    , .o_fault        (o_fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int got_q[$];
  int sel_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected coin list from plain division; returns the leftover below 100.
  function automatic int greedy(input int total);
    int rem;
    exp_q.delete();
    rem = total;
    repeat (rem / 1000) exp_q.push_back(1000);
    rem = rem % 1000;
    repeat (rem / 500) exp_q.push_back(500);
    rem = rem % 500;
    repeat (rem / 100) exp_q.push_back(100);
    return rem % 100;
  endfunction

  function automatic int sel_to_val(input logic [2:0] sel);
    case (sel)
      3'b001:  return 100;
      3'b010:  return 500;
      3'b100:  return 1000;
      default: return -1;
    endcase
  endfunction

  task automatic do_reset(input int total);
    @(negedge clk);
    reset_n = 1'b0;
    i_total = TB_BITS'(total);
    i_trigger_return = 1'b0;
    i_activity = 1'b0;
    i_coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", o_coin_req, 0);
    check("rst_sel", o_coin_sel, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_subv", o_sub_valid, 0);
    check("rst_residue", o_residue, 0);
    check("rst_wait", o_wait_time, 100);
    reset_n = 1'b1;
  endtask

  // Plays the hopper for one return sequence and scores it against the model.
  task automatic monitor_return(input string tag, input int total, input int ack_delay,
                                output int done_cycle);
    int  res;
    int  req_cnt;
    bit  prev_req;
    bit  seen_req;
    logic [2:0] held_sel;
    res = greedy(total);
    got_q.delete();
    sel_q.delete();
    req_cnt = 0;
    prev_req = 1'b0;
    seen_req = 1'b0;
    held_sel = 3'b000;
    done_cycle = -1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      i_trigger_return = 1'b0;
      if (o_sub_valid) got_q.push_back(int'(o_sub_val));
      else if (o_sub_val != '0) check({tag, "_subval_idle"}, o_sub_val, 0);
      if (o_coin_req) begin
        seen_req = 1'b1;
        if (!prev_req) begin
          sel_q.push_back(sel_to_val(o_coin_sel));
          held_sel = o_coin_sel;
        end else if (o_coin_sel != held_sel) begin
          check({tag, "_sel_stable"}, o_coin_sel, held_sel);
        end
        i_coin_ack = (req_cnt >= ack_delay);
        req_cnt++;
      end else begin
        i_coin_ack = 1'b0;
        req_cnt = 0;
      end
      prev_req = o_coin_req;
      if (o_done) begin
        done_cycle = cyc;
        break;
      end
    end
    i_coin_ack = 1'b0;
    check({tag, "_done_seen"}, done_cycle > 0, 1);
    check({tag, "_req_seen"}, seen_req, exp_q.size() > 0);
    check({tag, "_ncoins"}, got_q.size(), exp_q.size());
    check({tag, "_nsel"}, sel_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check({tag, "_subval"}, (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
      check({tag, "_sel"}, (i < sel_q.size()) ? sel_q[i] : -1, exp_q[i]);
    end
    check({tag, "_residue"}, o_residue, res);
    i_total = '0;
    @(negedge clk);
    check({tag, "_done_pulse"}, o_done, 0);
    check({tag, "_idle"}, o_busy, 0);
    check({tag, "_wait_reload"}, o_wait_time, 100);
  endtask

  task automatic trigger_return(input string tag, input int total, input int ack_delay,
                                output int done_cycle);
    @(negedge clk);
    i_total = TB_BITS'(total);
    i_trigger_return = 1'b1;
    monitor_return(tag, total, ack_delay, done_cycle);
  endtask

  task automatic count_to_busy(input string tag, input int expected);
    int cnt;
    cnt = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (o_busy) begin
        cnt = c;
        break;
      end
    end
    check(tag, cnt, expected);
  endtask

  initial begin
    int dc;
    int tot;
    int dly;
    bit got_req;

    // Idle-timeout return straight out of reset.
    do_reset(700);
    count_to_busy("timeout_start", 101);
    monitor_return("timeout", 700, 0, dc);

    // Activity halfway through the countdown restarts it.
    do_reset(700);
    repeat (50) @(negedge clk);
    check("act_wait50", o_wait_time, 50);
    i_activity = 1'b1;
    @(negedge clk);
    i_activity = 1'b0;
    check("act_reload", o_wait_time, 100);
    count_to_busy("act_start", 101);
    monitor_return("activity", 700, 0, dc);

    trigger_return("t1600", 1600, 0, dc);
    trigger_return("t650", 650, 0, dc);
    trigger_return("t0", 0, 0, dc);
    check("t0_done_cycle", dc, 2);

    for (int n = 0; n < 20; n++) begin
      tot = (n % 5 == 0) ? $urandom_range(0, 199) : $urandom_range(0, 5000);
      dly = $urandom_range(0, 3);
      trigger_return("rand", tot, dly, dc);
    end

    // Reset in the middle of a handshake.
    @(negedge clk);
    i_total = TB_BITS'(1600);
    i_trigger_return = 1'b1;
    got_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_trigger_return = 1'b0;
      if (o_coin_req) begin
        got_req = 1'b1;
        break;
      end
    end
    check("midrst_req_before", got_req, 1);
    reset_n = 1'b0;
    i_total = '0;
    @(negedge clk);
    check("midrst_req", o_coin_req, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_subv", o_sub_valid, 0);
    reset_n = 1'b1;

`ifdef CHANGE_RETURN_ACK_TIMEOUT_EN
    begin
      int req_cycles;
      req_cycles = 0;
      dc = -1;
      @(negedge clk);
      i_total = TB_BITS'(1600);
      i_trigger_return = 1'b1;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        i_trigger_return = 1'b0;
        if (o_coin_req) req_cycles++;
        if (o_sub_valid) check("flt_no_sub", o_sub_valid, 0);
        if (o_done) begin
          dc = c;
          break;
        end
      end
      check("flt_done_seen", dc > 0, 1);
      check("flt_req_cycles", req_cycles, 16);
      check("flt_fault", o_fault, 1);
      check("flt_residue", o_residue, 1600);
      i_total = '0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_return_ctrl.md
Name: change_return_ctrl

Overview:
- Sequences change return for the vending machine.
- Decides when a return starts: on explicit trigger, or when the idle countdown expires with a nonzero balance.
- Once started, dispenses coins one at a time to the coin hopper using a greedy largest-coin-first order over a req/ack handshake.
- Reports each dispensed coin's value so the balance register upstream can subtract it; sits between the balance datapath and the hopper driver.

Parameters:
- TOTAL_BITS, 31, width of balance values.
- WAIT_TIME, 100, idle countdown reload value in cycles.
- COIN0_VAL, 100, value of coin index 0 (smallest).
- COIN1_VAL, 500, value of coin index 1.
- COIN2_VAL, 1000, value of coin index 2 (largest); COIN0_VAL < COIN1_VAL < COIN2_VAL required.
- ACK_LIMIT, 16, hopper ack watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset_n  input  1  synchronous, active-low reset.
- i_total  input  TOTAL_BITS  current customer balance from the balance register.
- i_trigger_return  input  1  user return request; level-sampled.
- i_activity  input  1  coin inserted or item selected this cycle.
- i_coin_ack  input  1  hopper has released the requested coin.
- o_coin_req  output  1  dispense request to the hopper.
- o_coin_sel  output  3  one-hot coin index for the request.
- o_sub_valid  output  1  one-cycle pulse: subtract o_sub_val from the balance.
- o_sub_val  output  TOTAL_BITS  value of the coin just dispensed; 0 when o_sub_valid=0.
- o_busy  output  1  return sequence in progress.
- o_done  output  1  one-cycle pulse at the end of a return sequence.
- o_residue  output  TOTAL_BITS  remainder below COIN0_VAL left after the last return.
- o_wait_time  output  32  current idle countdown value.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State=IDLE, remaining=0, wait_time=WAIT_TIME.
  - All outputs 0 except o_wait_time=WAIT_TIME.
  - Reset mid-sequence drops o_coin_req on the next edge, with no o_sub_valid and no o_done.
- IDLE:
  - i_trigger_return=1: latch remaining<=i_total and go to SELECT. Trigger wins over i_activity in the same cycle.
  - Otherwise, if wait_time==0 and i_total!=0: latch remaining and go to SELECT.
  - Otherwise, i_activity=1: wait_time<=WAIT_TIME; else if wait_time>0, decrement by 1.
  - wait_time==0 with i_total==0: stay in IDLE, hold wait_time at 0 until activity.
- SELECT (1 cycle):
  - Pick the largest coin with value <= remaining and register o_coin_sel; go to DISPENSE.
  - No coin fits: o_residue<=remaining, go to DONE.
  - Trigger with i_total=0 goes IDLE->SELECT->DONE with zero coins.
- DISPENSE:
  - o_coin_req=1; o_coin_sel held stable while req is high.
  - On a posedge sampling i_coin_ack=1: remaining<=remaining-coin value, pulse o_sub_valid with o_sub_val=coin value, drop o_coin_req, go to SELECT.
  - One coin per handshake; minimum 2 cycles per coin.
- DONE (1 cycle):
  - o_done=1, wait_time<=WAIT_TIME, go to IDLE.
- o_busy=1 in SELECT, DISPENSE and DONE.
- i_activity and i_trigger_return are ignored while busy. i_total is not re-sampled while busy; remaining is authoritative.
- Subtraction never underflows, because a coin is selected only if value <= remaining.
- i_coin_ack outside DISPENSE is ignored.

Optional Feature:
- Macro: CHANGE_RETURN_ACK_TIMEOUT_EN.
- Defined:
  - An ack watchdog counts cycles in DISPENSE.
  - If ACK_LIMIT cycles elapse without ack: drop o_coin_req, no subtraction, o_residue<=remaining, assert output o_fault (1 bit, sticky until reset), go to DONE.
- Undefined: DISPENSE waits indefinitely for ack; o_fault port is absent.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> all outputs 0, o_wait_time=100, o_busy=0.
- Trigger with i_total=1600, hopper acking 1 cycle after each req:
  - o_coin_sel sequence 100, 010, 001.
  - o_sub_val 1000, 500, 100.
  - One o_done pulse, o_residue=0.
- Timeout: i_total=700, no activity for 100 cycles -> return starts when wait_time==0; coins 500, 100, 100; o_residue=0.
- Activity at cycle 50 of the countdown -> wait_time reloads to 100, and the return starts 100 cycles later.
- i_total=650 with trigger -> coins 500, 100; o_residue=50.
- i_total=0 with trigger -> o_done after 2 cycles with no o_coin_req.
- Reset asserted while o_coin_req=1 -> req low next cycle, state IDLE, no o_done.
- (_EN) Hopper never acks -> o_fault=1 after 16 cycles, o_done pulses, o_residue=i_total.
